// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O bridge for the CPU io port: LEDs, synchronized switches,
// button-latched input word, an output FIFO toward a valid/ready sink, and a cycle counter.
module io_bus_ctrl #(
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int PW = $clog2(OUT_DEPTH);

  localparam logic [5:0] OFS_LED    = 6'h00;
  localparam logic [5:0] OFS_SW     = 6'h01;
  localparam logic [5:0] OFS_STATUS = 6'h02;
  localparam logic [5:0] OFS_IN     = 6'h03;
  localparam logic [5:0] OFS_OUT    = 6'h04;
  localparam logic [5:0] OFS_CNT    = 6'h05;

  logic [5:0] ofs;
  assign ofs = io_addr[7:2];

  logic unused_addr;
  assign unused_addr = ^{io_addr[31:8], io_addr[1:0]};

  logic wr_led, wr_status, wr_out, wr_cnt;
  assign wr_led    = io_we && (ofs == OFS_LED);
  assign wr_status = io_we && (ofs == OFS_STATUS);
  assign wr_out    = io_we && (ofs == OFS_OUT);
  assign wr_cnt    = io_we && (ofs == OFS_CNT);

  // Input synchronizers; btn_s3 holds the previous synchronized level for edge detection
  logic [15:0] sw_s1, sw_s2;
  logic        btn_s1, btn_s2, btn_s3, btn_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_rise = btn_s2 && !btn_s3;

  logic [15:0] led_q, in_data;
  logic        in_valid, in_ovf, out_ovf;
  logic        clr_iv, clr_io, clr_oo;
  assign clr_iv = wr_status && io_dout[0];
  assign clr_io = wr_status && io_dout[1];
  assign clr_oo = wr_status && io_dout[4];

  // A capture beats a same-cycle clear of in_valid, so the pending valid is treated as gone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_data  <= '0;
      in_valid <= 1'b0;
      in_ovf   <= 1'b0;
    end else begin
      if (clr_iv) in_valid <= 1'b0;
      if (clr_io) in_ovf   <= 1'b0;
      if (btn_rise) begin
        if (in_valid && !clr_iv) begin
          in_ovf <= 1'b1;
        end else begin
          in_data  <= sw_s2;
          in_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        led_q <= '0;
    else if (wr_led) led_q <= io_dout[15:0];
  end
  assign led = led_q;

  // Output FIFO
  logic [31:0]   mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, pop, push_ok;

  assign full    = (count == (PW+1)'(OUT_DEPTH));
  assign empty   = (count == '0);
  assign pop     = !empty && out_ready;
  assign push_ok = wr_out && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (clr_oo) out_ovf <= 1'b0;
      if (wr_out && !push_ok) out_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= io_dout;
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;

  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (wr_cnt) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

  always_comb begin
    io_din = 32'h0;
    case (ofs)
      OFS_LED:    io_din = {16'h0, led_q};
      OFS_SW:     io_din = {16'h0, sw_s2};
      OFS_STATUS: io_din = {27'h0, out_ovf, empty, full, in_ovf, in_valid};
      OFS_IN:     io_din = {16'h0, in_data};
      OFS_CNT:    io_din = 32'(cnt);
      default:    io_din = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: register map, button latch, output FIFO and reset.
module tb_io_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] io_addr = '0, io_dout = '0, io_din;
  logic        io_we = 1'b0;
  logic [15:0] sw = '0, led;
  logic        btn = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  int checks = 0, failures = 0;

  io_bus_ctrl #(.OUT_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_din(io_din), .sw(sw), .btn(btn), .led(led), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Inputs change on the falling edge; stores are a single-cycle strobe.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_dout = d; io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    checks++;
    if (io_din !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, io_din, exp);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (led !== 16'h0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs led=%h valid=%b data=%h exp 0/0/0", led, out_valid, out_data);
    end
    load_chk("reset_led", 32'h00, 32'h0);
    load_chk("reset_status", 32'h08, 32'h8);
    load_chk("reset_cnt", 32'h14, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    load_chk("cnt_after3", 32'h14, 32'd3);
    @(negedge clk);
    load_chk("cnt_after4", 32'h14, 32'd4);
  endtask

  task automatic test_cnt_clear;
    store(32'h14, 32'hDEAD);
    load_chk("cnt_cleared", 32'h14, 32'd0);
    @(negedge clk);
    load_chk("cnt_one", 32'h14, 32'd1);
  endtask

  task automatic test_led;
    store(32'h00, 32'h0000ABCD);
    #1;
    checks++;
    if (led !== 16'hABCD) begin
      failures++;
      $display("FAIL led_out got=%h exp=abcd", led);
    end
    load_chk("led_read", 32'h00, 32'h0000ABCD);
    store(32'hFFFFFF00, 32'hFFFF1234);
    load_chk("led_upper_ignored", 32'h00, 32'h00001234);
    load_chk("unmapped_read", 32'h18, 32'h0);
    load_chk("out_reads_zero", 32'h10, 32'h0);
    store(32'h00, 32'h0000ABCD);
  endtask

  task automatic press(input logic [15:0] v);
    sw = v; btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_button;
    sw = 16'h1234; btn = 1'b1;
    repeat (2) @(negedge clk);
    load_chk("in_valid_latency2", 32'h08, 32'h8);
    @(negedge clk);
    load_chk("in_valid_latency3", 32'h08, 32'h9);
    load_chk("in_data_first", 32'h0C, 32'h1234);
    load_chk("sw_sync", 32'h04, 32'h1234);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press(16'h5555);
    load_chk("in_ovf_set", 32'h08, 32'hB);
    load_chk("in_data_held", 32'h0C, 32'h1234);
    store(32'h08, 32'h3);
    load_chk("status_w1c", 32'h08, 32'h8);
  endtask

  task automatic test_edge_vs_clear;
    press(16'h0AAA);
    load_chk("pre_coincide", 32'h08, 32'h9);
    sw = 16'h0F0F; btn = 1'b1;
    repeat (2) @(negedge clk);
    store(32'h08, 32'h1);
    load_chk("coincide_status", 32'h08, 32'h9);
    load_chk("coincide_data", 32'h0C, 32'h0F0F);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    store(32'h08, 32'h3);
  endtask

  task automatic drain(input string name, input logic [31:0] exp[4]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        failures++;
        $display("FAIL %s[%0d] valid=%b data=%h exp=%h", name, i, out_valid, out_data, exp[i]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL %s_empty valid=%b data=%h exp 0/0", name, out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] exp[4];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 1'b0;
    store(32'h10, 32'h11);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11) begin
      failures++;
      $display("FAIL first_push valid=%b data=%h exp 1/11", out_valid, out_data);
    end
    store(32'h10, 32'h22);
    store(32'h10, 32'h33);
    store(32'h10, 32'h44);
    store(32'h10, 32'h55);
    load_chk("fifo_full_ovf", 32'h08, 32'h14);
    drain("ovf_drain", exp);
    store(32'h08, 32'h10);
    load_chk("out_ovf_clear", 32'h08, 32'h8);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp[4];
    exp = '{32'hA2, 32'hA3, 32'hA4, 32'h66};
    store(32'h10, 32'hA1);
    store(32'h10, 32'hA2);
    store(32'h10, 32'hA3);
    store(32'h10, 32'hA4);
    out_ready = 1'b1;
    store(32'h10, 32'h66);
    out_ready = 1'b0;
    load_chk("full_push_pop", 32'h08, 32'h4);
    drain("b2b_drain", exp);
  endtask

  task automatic test_reset_mid;
    store(32'h10, 32'hC1);
    store(32'h10, 32'hC2);
    store(32'h10, 32'hC3);
    out_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || led !== 16'h0) begin
      failures++;
      $display("FAIL async_reset valid=%b data=%h led=%h exp 0/0/0", out_valid, out_data, led);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_chk("post_reset_status", 32'h08, 32'h8);
  endtask

  initial begin
    test_reset();
    test_cnt_clear();
    test_led();
    test_button();
    test_edge_vs_clear();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
